// File: rtl/mac_pkg.sv
// Shared types and constants for the operand-buffer MAC.
// Build option: MAC_SAT_EN selects a saturating accumulator (see mac_datapath).
package mac_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} mac_state_e;

    localparam int DATA_W_DEF = 8;
    localparam int BUF_W_DEF  = 2;
    localparam int ACC_W_DEF  = 20;

    // Signed limit of a w-bit two's-complement value, returned in 64 bits;
    // the low w bits are the limit itself.
    function automatic logic [63:0] sat_limit(input int unsigned w, input logic neg);
        logic [63:0] m;
        m = 64'd1 << (w - 1);
        sat_limit = neg ? (~m + 64'd1) : (m - 64'd1);
    endfunction

endpackage

// File: rtl/buffer_mac_if.sv
// Handshake and buffer read bus between buffer_mac and its surroundings.
// master: the side that issues jobs, serves buffer reads and consumes Result.
// slave : buffer_mac itself.
interface buffer_mac_if #(
    parameter int DataWidth   = 8,
    parameter int BufferWidth = 2,
    parameter int AccWidth    = 20
);
    logic                          Start;
    logic [BufferWidth:0]          Len;
    logic [BufferWidth-1:0]        A_Base;
    logic [BufferWidth-1:0]        B_Base;
    logic [BufferWidth-1:0]        R_Addr1;
    logic [BufferWidth-1:0]        R_Addr2;
    logic signed [DataWidth-1:0]   DataIn1;
    logic signed [DataWidth-1:0]   DataIn2;
    logic                          Busy;
    logic signed [AccWidth-1:0]    Result;
    logic                          Valid;
    logic                          Ready;
    logic                          Overflow;

    modport master (
        output Start, Len, A_Base, B_Base, DataIn1, DataIn2, Ready,
        input  R_Addr1, R_Addr2, Busy, Result, Valid, Overflow
    );

    modport slave (
        input  Start, Len, A_Base, B_Base, DataIn1, DataIn2, Ready,
        output R_Addr1, R_Addr2, Busy, Result, Valid, Overflow
    );
endinterface

// File: rtl/mac_datapath.sv
// Product register plus accumulator. With MAC_SAT_EN defined the accumulator
// clamps to the signed AccWidth range and raises a sticky ovf; otherwise it
// wraps and ovf is constant 0.
module mac_datapath
    import mac_pkg::*;
#(
    parameter int DataWidth = DATA_W_DEF,
    parameter int AccWidth  = ACC_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,     // job accepted: zero prod/acc/ovf
    input  logic                        mul_en,  // capture a*b
    input  logic                        acc_en,  // fold previous prod into acc
    input  logic signed [DataWidth-1:0] a,
    input  logic signed [DataWidth-1:0] b,
    output logic signed [AccWidth-1:0]  acc,
    output logic                        ovf
);

    logic signed [2*DataWidth-1:0] prod;

    // Product register: one cycle between buffer read and accumulate.
    always_ff @(posedge clk) begin
        if (rst || clr)
            prod <= '0;
        else if (mul_en)
            prod <= a * b;
    end

`ifdef MAC_SAT_EN
    localparam logic [AccWidth-1:0] ACC_MAX = AccWidth'(sat_limit(AccWidth, 1'b0));
    localparam logic [AccWidth-1:0] ACC_MIN = AccWidth'(sat_limit(AccWidth, 1'b1));

    // One guard bit: top two bits disagree exactly when the add overflowed.
    logic signed [AccWidth:0] sum;
    assign sum = {acc[AccWidth-1], acc} + (AccWidth+1)'(prod);

    // Saturating accumulator with sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (acc_en) begin
            if (sum[AccWidth] != sum[AccWidth-1]) begin
                acc <= sum[AccWidth] ? ACC_MIN : ACC_MAX;
                ovf <= 1'b1;
            end else begin
                acc <= sum[AccWidth-1:0];
            end
        end
    end
`else
    logic signed [AccWidth-1:0] sum;
    assign sum = acc + AccWidth'(prod);

    // Wrapping accumulator.
    always_ff @(posedge clk) begin
        if (rst || clr)
            acc <= '0;
        else if (acc_en)
            acc <= sum;
    end

    assign ovf = 1'b0;
`endif

endmodule

// File: rtl/buffer_mac.sv
// buffer_mac: sweeps Len operand pairs out of a two-read-port buffer and
// returns their signed dot product on a Valid/Ready handshake.
// Build option: MAC_SAT_EN (saturating accumulator, sticky Overflow).
module buffer_mac
    import mac_pkg::*;
#(
    parameter int DataWidth   = DATA_W_DEF,
    parameter int BufferWidth = BUF_W_DEF,
    parameter int AccWidth    = ACC_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    buffer_mac_if.slave  bus
);

    mac_state_e               state;
    logic [BufferWidth:0]     len_q;
    logic [BufferWidth:0]     idx;
    logic [BufferWidth-1:0]   addr1_q;
    logic [BufferWidth-1:0]   addr2_q;
    logic                     busy_q;
    logic                     valid_q;
    logic                     start_ok;
    logic signed [AccWidth-1:0] acc;
    logic                     ovf;

    assign start_ok = (state == IDLE) && bus.Start;

    // Controller: job sequencing, address walk and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            len_q   <= '0;
            idx     <= '0;
            addr1_q <= '0;
            addr2_q <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.Start) begin
                    len_q  <= bus.Len;
                    idx    <= '0;
                    busy_q <= 1'b1;
                    if (bus.Len != '0) begin
                        state   <= RUN;
                        addr1_q <= bus.A_Base;
                        addr2_q <= bus.B_Base;
                    end else begin
                        // Empty job: nothing to read, result is the cleared acc.
                        state   <= DONE;
                        valid_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (idx == len_q - 1'b1) begin
                        state <= DRAIN;
                    end else begin
                        idx     <= idx + 1'b1;
                        addr1_q <= addr1_q + 1'b1;  // wraps mod buffer depth
                        addr2_q <= addr2_q + 1'b1;
                    end
                end
                DRAIN: begin
                    state   <= DONE;
                    valid_q <= 1'b1;
                end
                DONE: if (bus.Ready) begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    mac_datapath #(
        .DataWidth (DataWidth),
        .AccWidth  (AccWidth)
    ) u_dp (
        .clk    (clk),
        .rst    (rst),
        .clr    (start_ok),
        .mul_en (state == RUN),
        .acc_en (state == RUN || state == DRAIN),
        .a      (bus.DataIn1),
        .b      (bus.DataIn2),
        .acc    (acc),
        .ovf    (ovf)
    );

    assign bus.R_Addr1  = addr1_q;
    assign bus.R_Addr2  = addr2_q;
    assign bus.Busy     = busy_q;
    assign bus.Valid    = valid_q;
    assign bus.Result   = acc;
    assign bus.Overflow = ovf;

endmodule

// File: tb/tb_buffer_mac.sv
// Bench for buffer_mac: a 4-entry operand buffer model feeds the DUT; every
// job's result is predicted by a plain dot-product model over the buffer.
module tb_buffer_mac;

    localparam int DW = 8;
    localparam int BW = 2;
    localparam int AW = 16;
    localparam int DEPTH = 1 << BW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    buffer_mac_if #(.DataWidth(DW), .BufferWidth(BW), .AccWidth(AW)) bus ();

    buffer_mac #(.DataWidth(DW), .BufferWidth(BW), .AccWidth(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Operand buffer: combinational read ports.
    logic signed [DW-1:0] mem [DEPTH];
    assign bus.DataIn1 = mem[bus.R_Addr1];
    assign bus.DataIn2 = mem[bus.R_Addr2];

    int vec = 0;
    int err = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        vec++;
        if (obs !== exp) begin
            err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Dot product of the addressed pairs, AW-bit signed, wrap or clamp per step.
    task automatic model(input int ab, input int bb, input int ln,
                         output longint res, output bit ov);
        longint acc;
        longint lo, hi;
        lo = -(longint'(1) << (AW - 1));
        hi = (longint'(1) << (AW - 1)) - 1;
        acc = 0;
        ov  = 1'b0;
        for (int i = 0; i < ln; i++) begin
            acc = acc + longint'(mem[(ab + i) % DEPTH]) * longint'(mem[(bb + i) % DEPTH]);
`ifdef MAC_SAT_EN
            if (acc > hi) begin acc = hi; ov = 1'b1; end
            if (acc < lo) begin acc = lo; ov = 1'b1; end
`else
            acc = acc & ((longint'(1) << AW) - 1);
            if (acc > hi) acc = acc - (longint'(1) << AW);
`endif
        end
        res = acc;
    endtask

    // One full job: start, address walk, latency, result, back-pressure, accept.
    task automatic run_job(input int ab, input int bb, input int ln,
                           input int dly, input bit inject);
        longint exp_r;
        bit     exp_o;
        int     n;
        bit     got;
        int     lat;
        logic [BW:0]   l3;
        logic [BW-1:0] a2, b2;
        model(ab, bb, ln, exp_r, exp_o);
        l3 = (BW+1)'(ln);
        a2 = BW'(ab);
        b2 = BW'(bb);
        @(negedge clk);
        bus.Start  = 1'b1;
        bus.Len    = l3;
        bus.A_Base = a2;
        bus.B_Base = b2;
        bus.Ready  = (dly == 0);
        @(posedge clk); #1;
        bus.Start = 1'b0;
        n   = 0;
        got = bus.Valid;
        while (!got && n < 12) begin
            if (n < ln) begin
                chk("raddr1", bus.R_Addr1, (ab + n) % DEPTH);
                chk("raddr2", bus.R_Addr2, (bb + n) % DEPTH);
            end
            if (inject && n == 1) begin
                bus.Start  = 1'b1;
                bus.Len    = 1;
                bus.A_Base = a2 + 1'b1;
                bus.B_Base = b2 + 1'b1;
            end
            @(posedge clk); #1;
            bus.Start = 1'b0;
            n++;
            got = bus.Valid;
        end
        lat = (ln == 0) ? 0 : ln + 1;
        chk("latency", got ? n : -1, lat);
        chk("result", bus.Result, exp_r);
        chk("overflow", bus.Overflow, exp_o);
        chk("busy_done", bus.Busy, 1);
        if (dly > 0) begin
            repeat (dly) @(posedge clk);
            #1;
            chk("hold_valid", bus.Valid, 1);
            chk("hold_result", bus.Result, exp_r);
            bus.Ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("accept_valid", bus.Valid, 0);
        chk("accept_busy", bus.Busy, 0);
        chk("after_result", bus.Result, exp_r);
        bus.Ready = 1'b0;
    endtask

    initial begin
        bus.Start = 1'b0; bus.Len = '0; bus.A_Base = '0; bus.B_Base = '0; bus.Ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", bus.Valid, 0);
        chk("rst_busy", bus.Busy, 0);
        chk("rst_result", bus.Result, 0);
        chk("rst_ovf", bus.Overflow, 0);
        chk("rst_addr1", bus.R_Addr1, 0);
        chk("rst_addr2", bus.R_Addr2, 0);
        rst = 1'b0;

        // Directed: simple squares, then wrapped addresses with mixed signs.
        mem[0] = 1; mem[1] = 2; mem[2] = 3; mem[3] = 4;
        run_job(0, 0, 4, 0, 1'b0);
        mem[0] = -3; mem[1] = 5; mem[2] = 2; mem[3] = -7;
        run_job(2, 1, 4, 0, 1'b0);
        run_job(1, 3, 0, 0, 1'b0);
        run_job(3, 0, 4, 0, 1'b1);
        run_job(0, 2, 3, 3, 1'b0);

        // Reset mid-job, then a clean job afterwards.
        @(negedge clk);
        bus.Start = 1'b1; bus.Len = 4; bus.A_Base = 0; bus.B_Base = 1; bus.Ready = 1'b1;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_valid", bus.Valid, 0);
        chk("midrst_busy", bus.Busy, 0);
        chk("midrst_result", bus.Result, 0);
        chk("midrst_addr1", bus.R_Addr1, 0);
        rst = 1'b0;
        run_job(0, 1, 4, 0, 1'b0);

        // Large operands: overflow of the 16-bit accumulator.
        for (int i = 0; i < DEPTH; i++) mem[i] = 127;
        run_job(0, 0, 4, 0, 1'b0);
        for (int i = 0; i < DEPTH; i++) mem[i] = -128;
        run_job(1, 2, 4, 1, 1'b0);

        // Randomized jobs.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
            run_job($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
                    $urandom_range(0, DEPTH), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
